// File: rtl/maxpool_sequencer_if.sv
// Handshake and config bundle between the main controller, the maxpool FIFO array
// and the row-pair maxpool sequencer.
interface maxpool_sequencer_if;
  logic       start;
  logic       pe_valid;
  logic       maxpool_mode;
  logic [1:0] maxpool_stride;
  logic [8:0] ofm_size_conv;
  logic [6:0] num_tile;
  logic       maxpool_rd_clr;
  logic       maxpool_wr_clr;
  logic       maxpool_rd_en;
  logic       maxpool_wr_en;
  logic       write_out_maxpool_en;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, pe_valid, maxpool_mode, maxpool_stride, ofm_size_conv, num_tile,
    input  maxpool_rd_clr, maxpool_wr_clr, maxpool_rd_en, maxpool_wr_en,
           write_out_maxpool_en, busy, done, err
  );

  modport slave (
    input  start, pe_valid, maxpool_mode, maxpool_stride, ofm_size_conv, num_tile,
    output maxpool_rd_clr, maxpool_wr_clr, maxpool_rd_en, maxpool_wr_en,
           write_out_maxpool_en, busy, done, err
  );
endinterface

// File: rtl/maxpool_sequencer.sv
// Vertical (row-pair) stage sequencer of the 2x2 maxpool datapath.
// Optional occupancy/protocol checking is compiled in with MAXPOOL_SEQ_CHECK_EN.
module maxpool_sequencer #(
  parameter int SYSTOLIC_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  maxpool_sequencer_if.slave   bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic       stride1_r;
  logic [8:0] n_r;
  logic [6:0] ntile_r;
  logic [8:0] row_r;
  logic [6:0] tile_r;
  logic       busy_r;
  logic       done_r;
  logic       clr_r;

  logic       start_acc_s;
  logic       beat_s;
  logic       last_row_s;
  logic       last_tile_s;
  logic       rd_en_s;
  logic       wr_en_s;

  assign start_acc_s = bus.start && (state_r == IDLE);
  assign beat_s      = bus.pe_valid && (state_r == RUN);
  assign last_row_s  = (row_r == (n_r - 9'd1));
  assign last_tile_s = (({1'b0, tile_r} + 8'd1) >= {1'b0, ntile_r});

  // Per-beat FIFO enable decode from the registered stride and row index.
  always_comb begin
    rd_en_s = 1'b0;
    wr_en_s = 1'b0;
    if (!beat_s || (n_r == 9'd1)) begin
      rd_en_s = 1'b0;
      wr_en_s = 1'b0;
    end else if (stride1_r) begin
      rd_en_s = (row_r != 9'd0);
      wr_en_s = !last_row_s;
    end else begin
      rd_en_s = row_r[0];
      wr_en_s = !row_r[0] && !last_row_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_acc_s) begin
          state_nxt_s = bus.maxpool_mode ? CLEAR : DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CLEAR: state_nxt_s = RUN;
      RUN: begin
        if (beat_s && last_row_s) begin
          state_nxt_s = last_tile_s ? DONE : CLEAR;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State and registered status outputs, all derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      clr_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= (state_nxt_s == DONE);
      clr_r   <= (state_nxt_s == CLEAR);
    end
  end

  // Layer configuration captured at an accepted start; zero sizes behave as one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stride1_r <= 1'b0;
      n_r       <= 9'd1;
      ntile_r   <= 7'd1;
    end else if (start_acc_s) begin
      stride1_r <= (bus.maxpool_stride == 2'd1);
      n_r       <= (bus.ofm_size_conv == 9'd0) ? 9'd1 : bus.ofm_size_conv;
      ntile_r   <= (bus.num_tile == 7'd0) ? 7'd1 : bus.num_tile;
    end else begin
      stride1_r <= stride1_r;
      n_r       <= n_r;
      ntile_r   <= ntile_r;
    end
  end

  // Row and tile counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_r  <= 9'd0;
      tile_r <= 7'd0;
    end else if (start_acc_s) begin
      row_r  <= 9'd0;
      tile_r <= 7'd0;
    end else if (state_r == CLEAR) begin
      row_r  <= 9'd0;
      tile_r <= tile_r;
    end else if (beat_s) begin
      if (last_row_s) begin
        row_r  <= 9'd0;
        tile_r <= tile_r + 7'd1;
      end else begin
        row_r  <= row_r + 9'd1;
        tile_r <= tile_r;
      end
    end else begin
      row_r  <= row_r;
      tile_r <= tile_r;
    end
  end

  assign bus.maxpool_rd_en        = rd_en_s;
  assign bus.maxpool_wr_en        = wr_en_s;
  assign bus.write_out_maxpool_en = rd_en_s;
  assign bus.maxpool_rd_clr       = clr_r;
  assign bus.maxpool_wr_clr       = clr_r;
  assign bus.busy                 = busy_r;
  assign bus.done                 = done_r;

`ifdef MAXPOOL_SEQ_CHECK_EN
  localparam int OCC_W = $clog2(SYSTOLIC_SIZE + 1);

  logic [OCC_W-1:0] occ_r;
  logic             full_s;
  logic             empty_s;
  logic             err_set_s;
  logic             err_r;

  assign full_s    = (occ_r == OCC_W'(SYSTOLIC_SIZE));
  assign empty_s   = (occ_r == {OCC_W{1'b0}});
  // A simultaneous pop frees the slot first, so push+pop while full is legal.
  assign err_set_s = (bus.pe_valid && (state_r != RUN))
                   || (wr_en_s && !rd_en_s && full_s)
                   || (rd_en_s && empty_s);

  // FIFO occupancy tracking, saturating at both ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_r <= {OCC_W{1'b0}};
    end else if (state_r == CLEAR) begin
      occ_r <= {OCC_W{1'b0}};
    end else if (wr_en_s && !rd_en_s && !full_s) begin
      occ_r <= occ_r + {{(OCC_W-1){1'b0}}, 1'b1};
    end else if (rd_en_s && !wr_en_s && !empty_s) begin
      occ_r <= occ_r - {{(OCC_W-1){1'b0}}, 1'b1};
    end else begin
      occ_r <= occ_r;
    end
  end

  // Sticky protocol error, cleared by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (start_acc_s) begin
      err_r <= 1'b0;
    end else if (err_set_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif

endmodule
